// File: rtl/jacobi_matrix_tx.sv
// rtl/jacobi_matrix_tx.sv - N x N matrix frame store that streams its contents row-major
//
// Purpose: holds one N*N frame of IN_WORD_WIDTH words loaded through a simple
// write port, and on request streams the frame out with valid/ready handshake.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_addr_i       element index (row*N+col) for loading
//   wr_dat_i        element value
//   wr_en_i         single-cycle write strobe
//   start_i         request to stream the stored frame
//   busy_o          high while streaming
//   done_o          one-cycle pulse after the last word is accepted
//   wr_err_o        one-cycle pulse when a write is rejected
//   out_dat_o       streamed word (registered)
//   out_vld_o       out_dat_o valid
//   out_rdy_i       downstream accepts the word
module jacobi_matrix_tx #(
   parameter int N             = 8,
   parameter int IN_WORD_WIDTH = 16,
   localparam int IDX_W        = $clog2(N*N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IDX_W-1:0]         wr_addr_i,
   input  logic [IN_WORD_WIDTH-1:0] wr_dat_i,
   input  logic                     wr_en_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     wr_err_o,
   output logic [IN_WORD_WIDTH-1:0] out_dat_o,
   output logic                     out_vld_o,
   input  logic                     out_rdy_i
);

   localparam int NN = N * N;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]               state;
   logic [IDX_W-1:0]         idx;
   logic [IN_WORD_WIDTH-1:0] mem [NN];

   logic             wr_ok;
   logic             wr_reject;
   logic             xfer;
   logic [IDX_W-1:0] next_idx;

   // Loading is only allowed outside STREAM and never in the same cycle as start.
   assign wr_ok     = wr_en_i && !start_i && (state != S_STREAM) && (int'(wr_addr_i) < NN);
   // A write collides with streaming either during STREAM or when it arrives with start in IDLE.
   assign wr_reject = wr_en_i && ((state == S_STREAM) || ((state == S_IDLE) && start_i));
   assign xfer      = (state == S_STREAM) && out_vld_o && out_rdy_i;
   assign next_idx  = idx + IDX_W'(1);
   assign busy_o    = (state == S_STREAM);

   // Storage has no reset so contents survive an aborted frame.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_addr_i] <= wr_dat_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         out_vld_o <= 1'b0;
         out_dat_o <= '0;
         done_o    <= 1'b0;
         wr_err_o  <= 1'b0;
      end else begin
         done_o   <= 1'b0;
         wr_err_o <= wr_reject;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state     <= S_STREAM;
                  idx       <= '0;
                  out_dat_o <= mem[0];
                  out_vld_o <= 1'b1;
               end
            end
            S_STREAM: begin
               if (xfer) begin
                  if (idx == LAST_IDX) begin
                     state     <= S_DONE;
                     out_vld_o <= 1'b0;
                     done_o    <= 1'b1;
                  end else begin
                     idx       <= next_idx;
                     out_dat_o <= mem[next_idx];
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               out_vld_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jacobi_matrix_tx.sv
// tb/tb_jacobi_matrix_tx.sv - self-checking bench for jacobi_matrix_tx
module tb_jacobi_matrix_tx;

   localparam int N     = 8;
   localparam int W     = 16;
   localparam int NN    = N * N;
   localparam int IDX_W = $clog2(NN);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [IDX_W-1:0] wr_addr_i = '0;
   logic [W-1:0]     wr_dat_i = '0;
   logic             wr_en_i = 1'b0;
   logic             start_i = 1'b0;
   logic             busy_o, done_o, wr_err_o, out_vld_o;
   logic [W-1:0]     out_dat_o;
   logic             out_rdy_i = 1'b0;

   int total = 0;
   int bad   = 0;

   jacobi_matrix_tx #(.N(N), .IN_WORD_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .wr_addr_i(wr_addr_i), .wr_dat_i(wr_dat_i), .wr_en_i(wr_en_i),
      .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .wr_err_o(wr_err_o),
      .out_dat_o(out_dat_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural reference: a frame is "in flight" from the accepted start until
   // the last of NN handshakes; the word on offer is always model_mem[pos].
   logic [W-1:0] model_mem [NN];
   bit           m_stream, m_after, m_vld, m_done, m_err;
   int           m_pos;
   logic [W-1:0] m_dat;

   initial for (int i = 0; i < NN; i++) model_mem[i] = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_stream <= 0; m_after <= 0; m_vld <= 0; m_done <= 0; m_err <= 0;
         m_pos <= 0; m_dat <= '0;
      end else begin
         m_done  <= 0;
         m_err   <= 0;
         m_after <= 0;
         if (m_stream) begin
            if (wr_en_i) m_err <= 1;
            if (out_rdy_i) begin
               if (m_pos == NN - 1) begin
                  m_stream <= 0; m_vld <= 0; m_done <= 1; m_after <= 1;
               end else begin
                  m_pos <= m_pos + 1;
                  m_dat <= model_mem[m_pos + 1];
               end
            end
         end else if (start_i && !m_after) begin
            m_stream <= 1; m_pos <= 0; m_vld <= 1; m_dat <= model_mem[0];
            if (wr_en_i) m_err <= 1;
         end else if (wr_en_i && !start_i && int'(wr_addr_i) < NN) begin
            model_mem[wr_addr_i] <= wr_dat_i;
         end
      end
   end

   // Per-cycle compare plus observation counters.
   logic [W-1:0] cap[$];
   int busy_cnt, done_cnt, err_cnt;

   always @(negedge clk) begin
      chk("out_vld", {31'd0, out_vld_o}, {31'd0, m_vld});
      chk("out_dat", {16'd0, out_dat_o}, {16'd0, m_dat});
      chk("busy",    {31'd0, busy_o},    {31'd0, m_stream});
      chk("done",    {31'd0, done_o},    {31'd0, m_done});
      chk("wr_err",  {31'd0, wr_err_o},  {31'd0, m_err});
      if (out_vld_o && out_rdy_i) cap.push_back(out_dat_o);
      if (busy_o)   busy_cnt++;
      if (done_o)   done_cnt++;
      if (wr_err_o) err_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs;
      cap.delete();
      busy_cnt = 0; done_cnt = 0; err_cnt = 0;
   endtask

   task automatic write(input int a, input int d);
      wr_addr_i = IDX_W'(a); wr_dat_i = W'(d); wr_en_i = 1'b1;
      tick;
      wr_en_i = 1'b0;
   endtask

   // mode 0: always ready; 1: stall 3 cycles on word 11; 2: write during stream
   // and start pulse at word 30 and in DONE; 3: random traffic.
   task automatic run_frame(input int mode);
      int stalls = 0;
      int budget = 0;
      bit wrote  = 0;
      clear_obs();
      start_i = 1'b1; out_rdy_i = 1'b1;
      tick;
      start_i = 1'b0;
      while (!done_o && budget < 600) begin
         out_rdy_i = 1'b1; start_i = 1'b0; wr_en_i = 1'b0;
         if (mode == 1 && out_vld_o && out_dat_o == W'(11) && stalls < 3) begin
            out_rdy_i = 1'b0; stalls++;
         end
         if (mode == 2) begin
            if (out_dat_o == W'(30)) start_i = 1'b1;
            if (out_dat_o == W'(40) && !wrote) begin
               wr_en_i = 1'b1; wr_addr_i = IDX_W'(5); wr_dat_i = 16'hBEEF; wrote = 1;
            end
         end
         if (mode == 3) begin
            out_rdy_i = ($urandom_range(0, 3) != 0);
            start_i   = ($urandom_range(0, 7) == 0);
            wr_en_i   = ($urandom_range(0, 7) == 0);
            wr_addr_i = IDX_W'($urandom_range(0, NN - 1));
            wr_dat_i  = W'($urandom);
         end
         tick;
         budget++;
      end
      chk("frame_done_seen", {31'd0, done_o}, 32'd1);
      wr_en_i = 1'b0;
      start_i = (mode == 2);
      tick;
      start_i = 1'b0;
      tick;
      chk("idle_after_frame", {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int b;
      logic [W-1:0] w;
      #2;
      chk("reset_vld", {31'd0, out_vld_o}, 32'd0);
      chk("reset_dat", {16'd0, out_dat_o}, 32'd0);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      tick;
      rst = 1'b0;
      tick;

      // Load mem[i] = i+1 and stream with no backpressure.
      for (int i = 0; i < NN; i++) write(i, i + 1);
      run_frame(0);
      chk("f0_words", cap.size(), 64);
      chk("f0_first", {16'd0, cap[0]}, 32'd1);
      chk("f0_last", {16'd0, cap[63]}, 32'd64);
      chk("f0_busy", busy_cnt, 64);
      chk("f0_done", done_cnt, 1);

      // Backpressure on word 11.
      run_frame(1);
      chk("bp_words", cap.size(), 64);
      chk("bp_w11", {16'd0, cap[10]}, 32'd11);
      chk("bp_w12", {16'd0, cap[11]}, 32'd12);
      chk("bp_busy", busy_cnt, 67);

      // Write during stream, start at word 30 and in DONE.
      run_frame(2);
      chk("ws_words", cap.size(), 64);
      chk("ws_done", done_cnt, 1);
      chk("ws_err", err_cnt, 1);
      run_frame(0);
      chk("ws_idx5", {16'd0, cap[5]}, 32'd6);

      // Reset after word 20.
      clear_obs();
      start_i = 1'b1; out_rdy_i = 1'b1;
      tick;
      start_i = 1'b0;
      b = 0;
      while (cap.size() < 20 && b < 200) begin tick; b++; end
      chk("rst_at20", cap.size(), 20);
      rst = 1'b1;
      #1;
      chk("rst_vld_now", {31'd0, out_vld_o}, 32'd0);
      chk("rst_busy_now", {31'd0, busy_o}, 32'd0);
      tick;
      rst = 1'b0;
      tick;
      chk("rst_no_done", done_cnt, 0);
      run_frame(0);
      chk("rst_words", cap.size(), 64);
      chk("rst_first", {16'd0, cap[0]}, 32'd1);
      chk("rst_last", {16'd0, cap[63]}, 32'd64);

      // Write and start together in IDLE.
      clear_obs();
      wr_en_i = 1'b1; wr_addr_i = '0; wr_dat_i = 16'h1234; start_i = 1'b1;
      tick;
      wr_en_i = 1'b0; start_i = 1'b0;
      chk("ws0_vld", {31'd0, out_vld_o}, 32'd1);
      chk("ws0_first", {16'd0, out_dat_o}, 32'd1);
      b = 0;
      while (!done_o && b < 200) begin tick; b++; end
      tick; tick;
      chk("ws0_err", err_cnt, 1);
      chk("ws0_words", cap.size(), 64);

      // Random loads and traffic against the model.
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 12; k++) write($urandom_range(0, NN - 1), $urandom);
         run_frame(3);
         chk("rnd_words", cap.size(), 64);
      end
      // Final check of stored contents by streaming them.
      run_frame(0);
      for (int i = 0; i < NN; i++) begin
         w = model_mem[i];
         chk("final_mem", {16'd0, cap[i]}, {16'd0, w});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jacobi_matrix_tx.md
JACOBI_MATRIX_TX -- requirements
Module: jacobi_matrix_tx

Interface
REQ-001 Parameter N, default 8: matrix dimension; the block streams one N x N frame of N*N words.
REQ-002 Parameter IN_WORD_WIDTH, default 16: width of one matrix element word.
REQ-003 Derived IDX_W = $clog2(N*N): width of the element index and write address.
REQ-004 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_addr_i  input  IDX_W  element index for loading, row-major (row*N+col).
REQ-007 wr_dat_i  input  IN_WORD_WIDTH  element value to store.
REQ-008 wr_en_i  input  1  single-cycle write strobe.
REQ-009 start_i  input  1  request to stream the stored frame.
REQ-010 busy_o  output  1  high while a frame is streaming.
REQ-011 done_o  output  1  one-cycle pulse after the last word of a frame is accepted.
REQ-012 wr_err_o  output  1  one-cycle pulse when a write is rejected.
REQ-013 out_dat_o  output  IN_WORD_WIDTH  streamed element word.
REQ-014 out_vld_o  output  1  out_dat_o is valid.
REQ-015 out_rdy_i  input  1  downstream (Jacobi core input) accepts the word.

Function
REQ-016 Storage SHALL be an N*N x IN_WORD_WIDTH array; it has no reset value.
REQ-017 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-018 In IDLE or DONE, wr_en_i with wr_addr_i < N*N and start_i low SHALL write wr_dat_i to mem[wr_addr_i] at the clock edge.
REQ-019 wr_en_i with wr_addr_i >= N*N SHALL be ignored, with no error.
REQ-020 In STREAM, wr_en_i SHALL NOT modify storage, and wr_err_o SHALL pulse high on the next cycle.
REQ-021 wr_en_i and start_i asserted together in IDLE SHALL: start the frame, discard the write, and pulse wr_err_o on the next cycle.
REQ-022 start_i sampled high in IDLE SHALL move the FSM to STREAM and set the index to 0.
REQ-023 out_vld_o SHALL be high with out_dat_o = mem[0] on the cycle after start_i is sampled (latency 1).
REQ-024 start_i SHALL be ignored in STREAM and in DONE.
REQ-025 A word is transferred when out_vld_o and out_rdy_i are both high at a clock edge.
REQ-026 Stream protocol:
- out_vld_o SHALL NOT deassert before its word is transferred.
- out_dat_o SHALL be stable while out_vld_o is high and out_rdy_i is low.
REQ-027 After transfer of word k < N*N-1, the next cycle SHALL present mem[k+1] with out_vld_o high (throughput one word per cycle).
REQ-028 Words SHALL be emitted in row-major order, index 0 to N*N-1, exactly once per frame.
REQ-029 Transfer of word N*N-1 SHALL:
- move the FSM to DONE;
- drive out_vld_o low on the next cycle;
- pulse done_o high for that single cycle.
REQ-030 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-031 busy_o SHALL equal (state == STREAM).
REQ-032 out_dat_o SHALL be registered and held at its last value while out_vld_o is low.

Reset
REQ-033 rst high SHALL immediately force:
- state = IDLE, index = 0;
- out_vld_o = 0, out_dat_o = 0;
- busy_o = 0, done_o = 0, wr_err_o = 0.
REQ-034 Reset during STREAM SHALL abort the frame with no done_o pulse; the next start_i SHALL stream from index 0.
REQ-035 Reset SHALL NOT alter storage contents.

Verification
REQ-036 N=8: write mem[i]=i+1 for i=0..63; start, out_rdy_i=1 -> words 1..64 on 64 consecutive cycles from start+1; done_o pulses on the cycle after word 64; busy_o is high for exactly 64 cycles.
REQ-037 Backpressure: out_rdy_i low for 3 cycles while word 11 is presented -> out_dat_o=11 held with out_vld_o high; stream resumes with 12; total frame length is 67 cycles.
REQ-038 wr_en_i to address 5 with value 0xBEEF during STREAM -> wr_err_o pulses once; the next frame emits 6 at index 5.
REQ-039 start_i pulsed at word 30 and during DONE -> no restart; exactly 64 words and one done_o pulse.
REQ-040 rst asserted after word 20 is transferred -> out_vld_o=0 and busy_o=0 immediately; no done_o; a new start streams 1..64 from index 0.
REQ-041 wr_en_i and start_i together in IDLE (addr 0, value 0x1234) -> frame starts, first word is the previous mem[0], wr_err_o pulses once.
